// File: rtl/softmax_grad.sv
// Softmax backward pass: dX_i = Y_i * (dY_i - sum_j Y_j*dY_j), signed Q(WIDTH-FBITS).FBITS.
// One multiplier is shared between a dot-product pass (DOT) and a per-element pass (GRAD).
module softmax_grad #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  parameter int FBITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N-1:0][WIDTH-1:0]   Y,
  input  logic [N-1:0][WIDTH-1:0]   dY,
  output logic [N-1:0][WIDTH-1:0]   dX,
  output logic                      busy,
  output logic                      done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2*WIDTH + 1;
  localparam int AW = PW + $clog2(N);

  localparam logic signed [AW-1:0] SMAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DOT, S_GRAD} state_t;

  state_t                    r_state, w_next;
  logic [N-1:0][WIDTH-1:0]   r_y, r_dy, r_dx;
  logic signed [AW-1:0]      r_acc;
  logic [IW-1:0]             r_idx;
  logic signed [WIDTH-1:0]   r_dot;
  logic                      r_done;

  logic                      w_last;
  logic signed [WIDTH-1:0]   w_y, w_dy;
  logic signed [WIDTH:0]     w_diff;
  logic signed [PW-1:0]      w_ya, w_mb, w_prod;
  logic signed [AW-1:0]      w_pext, w_acc_nx;
  logic [WIDTH-1:0]          w_dot_nx, w_dx_nx;

  // Floor shift then clamp to the signed WIDTH range.
  function automatic logic [WIDTH-1:0] f_sat(input logic signed [AW-1:0] x);
    logic signed [AW-1:0] sh;
    sh = x >>> FBITS;
    if (sh > SMAX)      sh = SMAX;
    else if (sh < SMIN) sh = SMIN;
    return sh[WIDTH-1:0];
  endfunction

  assign w_last = (r_idx == IW'(N-1));
  assign w_y    = r_y[r_idx];
  assign w_dy   = r_dy[r_idx];
  assign w_diff = {w_dy[WIDTH-1], w_dy} - {r_dot[WIDTH-1], r_dot};

  // Shared multiplier: dY in DOT, (dY - dot) in GRAD.
  assign w_ya   = {{(WIDTH+1){w_y[WIDTH-1]}}, w_y};
  assign w_mb   = (r_state == S_GRAD) ? {{WIDTH{w_diff[WIDTH]}}, w_diff}
                                      : {{(WIDTH+1){w_dy[WIDTH-1]}}, w_dy};
  assign w_prod = w_ya * w_mb;
  assign w_pext = {{(AW-PW){w_prod[PW-1]}}, w_prod};

  assign w_acc_nx = r_acc + w_pext;
  assign w_dot_nx = f_sat(w_acc_nx);
  assign w_dx_nx  = f_sat(w_pext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_DOT;
      S_DOT:   if (w_last) w_next = S_GRAD;
      S_GRAD:  if (w_last) w_next = S_IDLE;
      default:             w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y    <= '0;
      r_dy   <= '0;
      r_dx   <= '0;
      r_acc  <= '0;
      r_idx  <= '0;
      r_dot  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_y   <= Y;
          r_dy  <= dY;
          r_acc <= '0;
          r_idx <= '0;
        end
        S_DOT: begin
          r_acc <= w_acc_nx;
          if (w_last) begin
            r_dot <= w_dot_nx;
            r_idx <= '0;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_GRAD: begin
          r_dx[r_idx] <= w_dx_nx;
          if (w_last) begin
            r_done <= 1'b1;
            r_idx  <= '0;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: r_idx <= '0;
      endcase
    end
  end

  assign dX   = r_dx;
  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_softmax_grad.sv
// Directed bench for softmax_grad (N=4, WIDTH=32, FBITS=8): vector table plus
// hand-written sequences for ignored start, back-to-back start and mid-op reset.
module tb_softmax_grad;

  typedef struct {
    logic [3:0][31:0] y;
    logic [3:0][31:0] dy;
    logic [3:0][31:0] ex;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0][31:0] Y, dY, dX;
  logic             busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  softmax_grad #(.N(4), .WIDTH(32), .FBITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .Y(Y), .dY(dY),
    .dX(dX), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Present inputs, let edge E0 accept them, then scramble the inputs.
  task automatic launch(input vec_t v);
    @(negedge clk);
    Y = v.y; dY = v.dy; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    Y  = {4{32'hDEADBEEF}};
    dY = {4{32'h13572468}};
  endtask

  // Called #1 after E0; returns with sampling point #1 after the done edge.
  task automatic wait_done(input bit pulse, output int cyc, output int bc);
    cyc = 0; bc = 0;
    while (!done && cyc < 30) begin
      if (busy) bc++;
      if (pulse) start = (cyc == 2 || cyc == 6);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic chk_dx(input string nm, input vec_t v);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_dx%0d", nm, i), dX[i], v.ex[i]);
  endtask

  task automatic run_check(input string nm, input vec_t v, input bit pulse);
    int cyc, bc;
    launch(v);
    wait_done(pulse, cyc, bc);
    chk({nm, "_latency"}, 32'(cyc), 32'd8);
    chk({nm, "_busy_cycles"}, 32'(bc), 32'd8);
    chk({nm, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk_dx(nm, v);
    @(posedge clk); #1;
    chk({nm, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  vec_t tbl[5];

  initial begin
    int cyc, bc, seen;

    tbl[0].y  = {32'd64, 32'd64, 32'd64, 32'd64};
    tbl[0].dy = {32'd0, 32'd0, 32'd0, 32'd256};
    tbl[0].ex = {32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'd48};
    tbl[1].y  = {32'd64, 32'd64, 32'd64, 32'd64};
    tbl[1].dy = {32'd256, 32'd256, 32'd256, 32'd256};
    tbl[1].ex = {32'd0, 32'd0, 32'd0, 32'd0};
    tbl[2].y  = {32'd32, 32'd32, 32'd64, 32'd128};
    tbl[2].dy = {32'd256, 32'd0, 32'd512, 32'hFFFFFF00};
    tbl[2].ex = {32'd28, 32'hFFFFFFFC, 32'd120, 32'hFFFFFF70};
    tbl[3].y  = {32'd0, 32'd0, 32'h40000000, 32'h40000000} & {32'd0, 32'd0, 32'd0, 32'hFFFFFFFF};
    tbl[3].dy = {32'd0, 32'd0, 32'd0, 32'h40000000};
    tbl[3].ex = {32'd0, 32'd0, 32'd0, 32'h80000000};
    tbl[4].y  = {32'd0, 32'd0, 32'd256, 32'd128};
    tbl[4].dy = {32'd0, 32'd0, 32'd0, 32'hFFFFFFFF};
    tbl[4].ex = {32'd0, 32'd0, 32'd1, 32'd0};

    rst = 1'b1; start = 1'b0; Y = '0; dY = '0;
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_dx", dX[0] | dX[1] | dX[2] | dX[3], 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int k = 0; k < 5; k++)
      run_check($sformatf("vec%0d", k), tbl[k], 1'b0);

    // start pulses during DOT and GRAD must be ignored
    run_check("ignore_start", tbl[0], 1'b1);

    // start held through done launches the next row at E(2N+1)
    launch(tbl[2]);
    wait_done(1'b0, cyc, bc);
    chk("b2b_first_latency", 32'(cyc), 32'd8);
    chk_dx("b2b_first", tbl[2]);
    Y = tbl[0].y; dY = tbl[0].dy; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; Y = '1; dY = '1;
    chk("b2b_busy_after_accept", {31'd0, busy}, 32'd1);
    wait_done(1'b0, cyc, bc);
    chk("b2b_second_latency", 32'(cyc + 1), 32'd9);
    chk_dx("b2b_second", tbl[0]);

    // Prior op leaves dX = tbl[4].ex; abort after dX[1] of tbl[0] is written
    run_check("pre_reset", tbl[4], 1'b0);
    launch(tbl[0]);
    repeat (6) @(posedge clk);
    #1;
    chk("partial_dx0", dX[0], tbl[0].ex[0]);
    chk("partial_dx1", dX[1], tbl[0].ex[1]);
    chk("partial_dx2_kept", dX[2], tbl[4].ex[2]);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_dx", dX[0] | dX[1] | dX[2] | dX[3], 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_check("after_reset", tbl[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/softmax_grad.md
# softmax_grad

Backward-pass companion to the attention softmax: given a row of softmax outputs Y and upstream gradients dY, computes dX_i = Y_i * (dY_i - Σ_j Y_j·dY_j) in signed fixed point. Sits after the softmax in the attention training path and consumes its Out row, so its number format matches the softmax output format. Uses a single shared multiplier, time-multiplexed by a start/done FSM. A dot-product pass runs first, then a per-element gradient pass.

## Interface
- N, 4, row length (≥2)
- WIDTH, 32, signed word width of Y, dY, dX
- FBITS, 8, fractional bits (Q(WIDTH-FBITS).FBITS)
- Reset is rst, asynchronous, active-high. Clock is clk.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  request; sampled only in IDLE
- Y  in  [WIDTH-1:0] signed ×N  softmax outputs; captured on the accepting edge
- dY  in  [WIDTH-1:0] signed ×N  upstream gradients; captured on the accepting edge
- dX  out  [WIDTH-1:0] signed ×N  registered gradients
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse

## Operation
- FSM states:
  - IDLE: if start=1, capture Y and dY into internal registers, clear acc and idx, go to DOT. Otherwise stay.
  - DOT: each cycle, acc += Ysh[idx]·dYsh[idx] (full 2·WIDTH product, signed), idx++. After idx=N-1, compute dot, reset idx, go to GRAD.
  - GRAD: each cycle, dX[idx] <= sat(Ysh[idx]·(dYsh[idx]-dot) >>> FBITS), idx++. On idx=N-1, done<=1 and go to IDLE.
- Arithmetic:
  - acc width is 2·WIDTH+clog2(N), with no overflow.
  - dot = sat_WIDTH(acc >>> FBITS).
  - diff = dYsh[idx] - dot, computed at WIDTH+1 bits, with no overflow.
  - Product is (2·WIDTH+1) bits. Apply >>> FBITS, then saturate to WIDTH.
  - Shifts are arithmetic and round toward -∞ (floor). No rounding is added.
- Saturation clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1], applied both to dot and to each dX.
- start while busy is ignored. Inputs Y and dY may change freely after the accepting edge.
- dX entries not yet rewritten keep their previous values during GRAD. All N entries are valid when done=1 and stay valid until the next operation's GRAD pass.
- rst at any time, including mid-operation:
  - Immediately forces IDLE.
  - Clears dX, done, busy, acc, idx and the captured registers to 0.
  - No done pulse is produced for the aborted operation.

## Timing
- Edge E0 samples start=1 in IDLE. Edges E1..EN perform the N accumulations. Edges E(N+1)..E(2N) write dX[0]..dX[N-1].
- done is high in the cycle after E(2N) only, i.e. latency from the accepting edge to done = 2N edges (8 for N=4).
- busy is high from after E0 through E(2N); it clears on the same edge that sets done.
- A new start held high during the done cycle is accepted at E(2N+1). This gives a back-to-back throughput of one row per 2N+1 cycles.
- Reset values: dX=0 (all), done=0, busy=0.

## Test plan
- Uniform row, one-hot grad: N=4, FBITS=8, Y=[64,64,64,64] (0.25), dY=[256,0,0,0]. Expect dot=64, dX=[48,-16,-16,-16], done exactly 8 edges after start, busy high 8 cycles.
- Constant grad cancels: Y=[64,64,64,64], dY=[256,256,256,256]. Expect dot=256, dX=[0,0,0,0].
- Floor rounding: Y=[128,256,0,0], dY=[-1,0,0,0]. Expect acc=-128, dot=-1, dX=[0,1,0,0]; truncation toward zero would give dX1=0 and fails.
- Saturation: Y=[2^30,0,0,0], dY=[2^30,0,0,0]. Expect dot=0x7FFFFFFF and dX=[0x80000000,0,0,0].
- Protocol:
  - start pulsed during DOT and during GRAD is ignored, and the result equals the first test.
  - start held through done launches a second operation at E(2N+1) with new inputs, and correct dX is produced 9 cycles after the first done.
- Reset mid-operation: assert rst during GRAD after dX[1] is written. Expect dX all 0, busy=0, done=0 immediately, and no done pulse afterward. A fresh start after release reproduces the first test's results.
